// File: rtl/fft8_bf_scheduler.sv
// rtl/fft8_bf_scheduler.sv - frame buffer and butterfly scheduler for an 8-point radix-2 DIT FFT
module fft8_bf_scheduler #(
    parameter int DW     = 32,
    parameter int BF_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          bf_in_en,
    output logic [1:0]    bf_rotate,
    output logic [DW-1:0] bf_a_re,
    output logic [DW-1:0] bf_a_im,
    output logic [DW-1:0] bf_b_re,
    output logic [DW-1:0] bf_b_im,
    input  logic          bf_out_en,
    input  logic [DW-1:0] bf_c_re,
    input  logic [DW-1:0] bf_c_im,
    input  logic [DW-1:0] bf_d_re,
    input  logic [DW-1:0] bf_d_im
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_ISSUE  = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    n_q, n_d;
    logic [1:0]    s_q, s_d;
    logic [1:0]    j_q, j_d;
    logic [2:0]    ret_q, ret_d;
    logic [2:0]    outst_q, outst_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_re_q, out_re_d;
    logic [DW-1:0] out_im_q, out_im_d;
    logic [2:0]    out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;

    logic [DW-1:0] mem_re_q [8];
    logic [DW-1:0] mem_im_q [8];
    logic [DW-1:0] mem_re_d [8];
    logic [DW-1:0] mem_im_d [8];

    logic [2:0]    pend_top_q [BF_LAT];
    logic [2:0]    pend_bot_q [BF_LAT];
    logic          pend_vld_q [BF_LAT];

    logic          issue;
    logic          in_fire;
    logic          out_fire;
    logic          accept;
    logic          drain_done;
    logic [2:0]    top;
    logic [2:0]    bot;
    logic [1:0]    rot;
    logic [2:0]    wr_addr;

    assign issue      = (state_q == ST_ISSUE);
    assign in_fire    = in_valid && in_ready_q && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
    assign out_fire   = out_valid_q && out_ready;
    // A result is only taken when the shift line says one is due and an issue is still owed.
    assign accept     = bf_out_en && pend_vld_q[BF_LAT-1] && (outst_q != 3'd0);
    assign drain_done = ((ret_q + {2'b00, accept}) == 3'd4);
    assign wr_addr    = {n_q[0], n_q[1], n_q[2]};

    // Butterfly pair addresses and twiddle for stage s, butterfly j (span 1<<s).
    always_comb begin
        top = 3'd0;
        bot = 3'd0;
        rot = 2'd0;
        case (s_q)
            2'd0: begin
                top = {j_q, 1'b0};
                bot = {j_q, 1'b1};
                rot = 2'd0;
            end
            2'd1: begin
                top = {j_q[1], 1'b0, j_q[0]};
                bot = {j_q[1], 1'b1, j_q[0]};
                rot = {j_q[0], 1'b0};
            end
            default: begin
                top = {1'b0, j_q};
                bot = {1'b1, j_q};
                rot = j_q;
            end
        endcase
    end

    // Operands are read straight from the buffer so a new stage sees the previous stage's last write.
    assign bf_in_en  = issue;
    assign bf_rotate = issue ? rot : 2'd0;
    assign bf_a_re   = issue ? mem_re_q[top] : '0;
    assign bf_a_im   = issue ? mem_im_q[top] : '0;
    assign bf_b_re   = issue ? mem_re_q[bot] : '0;
    assign bf_b_im   = issue ? mem_im_q[bot] : '0;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);

    // Next buffer contents: bit-reversed sample loads and in-place butterfly write-back.
    always_comb begin
        mem_re_d = mem_re_q;
        mem_im_d = mem_im_q;
        if (in_fire) begin
            mem_re_d[wr_addr] = in_re;
            mem_im_d[wr_addr] = in_im;
        end
        if (accept) begin
            mem_re_d[pend_top_q[BF_LAT-1]] = bf_c_re;
            mem_im_d[pend_top_q[BF_LAT-1]] = bf_c_im;
            mem_re_d[pend_bot_q[BF_LAT-1]] = bf_d_re;
            mem_im_d[pend_bot_q[BF_LAT-1]] = bf_d_im;
        end
    end

    // Frame state machine; output bins are loaded from the next buffer value to see the final write.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        s_d         = s_q;
        j_d         = j_q;
        ret_d       = ret_q + {2'b00, accept};
        outst_d     = outst_q + {2'b00, issue} - {2'b00, accept};
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    n_d     = 3'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_fire) begin
                    n_d = n_q + 3'd1;
                    if (n_q == 3'd7) begin
                        state_d    = ST_ISSUE;
                        in_ready_d = 1'b0;
                        s_d        = 2'd0;
                        j_d        = 2'd0;
                        ret_d      = 3'd0;
                    end
                end
            end
            ST_ISSUE: begin
                j_d = j_q + 2'd1;
                if (j_q == 2'd3) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    ret_d = 3'd0;
                    j_d   = 2'd0;
                    if (s_q == 2'd2) begin
                        state_d     = ST_UNLOAD;
                        s_d         = 2'd0;
                        out_valid_d = 1'b1;
                        out_re_d    = mem_re_d[0];
                        out_im_d    = mem_im_d[0];
                        out_idx_d   = 3'd0;
                        out_last_d  = 1'b0;
                    end else begin
                        s_d     = s_q + 2'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_UNLOAD: begin
                if (out_fire) begin
                    if (out_idx_q == 3'd7) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        out_re_d    = '0;
                        out_im_d    = '0;
                        out_idx_d   = 3'd0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_idx_d  = out_idx_q + 3'd1;
                        out_re_d   = mem_re_d[out_idx_q + 3'd1];
                        out_im_d   = mem_im_d[out_idx_q + 3'd1];
                        out_last_d = (out_idx_q == 3'd6);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= 3'd0;
            s_q         <= 2'd0;
            j_q         <= 2'd0;
            ret_q       <= 3'd0;
            outst_q     <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            s_q         <= s_d;
            j_q         <= j_d;
            ret_q       <= ret_d;
            outst_q     <= outst_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    // Pair addresses follow each issue through a line as deep as the butterfly latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BF_LAT; i++) begin
                pend_top_q[i] <= 3'd0;
                pend_bot_q[i] <= 3'd0;
                pend_vld_q[i] <= 1'b0;
            end
        end else begin
            pend_top_q[0] <= top;
            pend_bot_q[0] <= bot;
            pend_vld_q[0] <= issue;
            for (int i = 1; i < BF_LAT; i++) begin
                pend_top_q[i] <= pend_top_q[i-1];
                pend_bot_q[i] <= pend_bot_q[i-1];
                pend_vld_q[i] <= pend_vld_q[i-1];
            end
        end
    end

    // Sample buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        mem_re_q <= mem_re_d;
        mem_im_q <= mem_im_d;
    end

endmodule

// File: tb/tb_fft8_bf_scheduler.sv
// tb/tb_fft8_bf_scheduler.sv - directed bench for fft8_bf_scheduler at BF_LAT 1 and 3
module tb_fft8_bf_scheduler;

    localparam logic [31:0] ONE = 32'h00010000;
    localparam logic [31:0] E   = 32'h00002000;
    localparam logic [31:0] NE  = 32'hFFFFE000;
    localparam logic [31:0] E2  = 32'h00004000;
    localparam logic [23:0] ROT_SEQ = 24'h00221B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid [2];
    logic        in_ready [2];
    logic [31:0] in_re [2];
    logic [31:0] in_im [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_re [2];
    logic [31:0] out_im [2];
    logic [2:0]  out_idx [2];
    logic        out_last [2];
    logic        busy [2];
    logic        bf_in_en [2];
    logic [1:0]  bf_rotate [2];
    logic [31:0] bf_a_re [2];
    logic [31:0] bf_a_im [2];
    logic [31:0] bf_b_re [2];
    logic [31:0] bf_b_im [2];
    logic        bf_out_en [2];
    logic [31:0] bf_c_re [2];
    logic [31:0] bf_c_im [2];
    logic [31:0] bf_d_re [2];
    logic [31:0] bf_d_im [2];
    logic        stray [2];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] fr_re [8];
    logic [31:0] fr_im [8];
    logic [31:0] ex_re [8];
    logic [31:0] ex_im [8];

    always #5 clk = ~clk;

    function automatic logic [127:0] bfly(input logic [31:0] ar, input logic [31:0] ai,
                                          input logic [31:0] br, input logic [31:0] bi,
                                          input logic [1:0] k);
        logic signed [63:0] sar, sai, sbr, sbi, wr, wi, r, cr, ci, dr, di;
        sar = 64'($signed(ar));
        sai = 64'($signed(ai));
        sbr = 64'($signed(br));
        sbi = 64'($signed(bi));
        r   = 64'sd46341;
        case (k)
            2'd0: begin wr = sbr; wi = sbi; end
            2'd1: begin wr = (r * (sbr + sbi)) >>> 16; wi = (r * (sbi - sbr)) >>> 16; end
            2'd2: begin wr = sbi; wi = -sbr; end
            default: begin wr = (r * (sbi - sbr)) >>> 16; wi = (r * (-sbi - sbr)) >>> 16; end
        endcase
        cr = (sar + wr) >>> 1;
        ci = (sai + wi) >>> 1;
        dr = (sar - wr) >>> 1;
        di = (sai - wi) >>> 1;
        return {cr[31:0], ci[31:0], dr[31:0], di[31:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;
        logic [127:0] pd [L];
        logic         pv [L];

        initial begin
            for (int i = 0; i < L; i++) begin
                pv[i] = 1'b0;
                pd[i] = '0;
            end
        end

        always @(posedge clk) begin
            pd[0] <= bfly(bf_a_re[g], bf_a_im[g], bf_b_re[g], bf_b_im[g], bf_rotate[g]);
            pv[0] <= bf_in_en[g];
            for (int i = 1; i < L; i++) begin
                pd[i] <= pd[i-1];
                pv[i] <= pv[i-1];
            end
        end

        assign bf_out_en[g] = pv[L-1] | stray[g];
        assign {bf_c_re[g], bf_c_im[g], bf_d_re[g], bf_d_im[g]} = pv[L-1] ? pd[L-1] : {4{32'hDEADBEEF}};

        fft8_bf_scheduler #(.DW(32), .BF_LAT(L)) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_re(in_re[g]), .in_im(in_im[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_re(out_re[g]), .out_im(out_im[g]),
            .out_idx(out_idx[g]), .out_last(out_last[g]), .busy(busy[g]),
            .bf_in_en(bf_in_en[g]), .bf_rotate(bf_rotate[g]),
            .bf_a_re(bf_a_re[g]), .bf_a_im(bf_a_im[g]), .bf_b_re(bf_b_re[g]), .bf_b_im(bf_b_im[g]),
            .bf_out_en(bf_out_en[g]), .bf_c_re(bf_c_re[g]), .bf_c_im(bf_c_im[g]),
            .bf_d_re(bf_d_re[g]), .bf_d_im(bf_d_im[g])
        );
    end

    task automatic check_idle(input int g, input string nm);
        logic [9:0]  ctl;
        logic [31:0] dat;
        ctl = {in_ready[g], out_valid[g], busy[g], bf_in_en[g], bf_rotate[g], out_last[g], out_idx[g]};
        dat = out_re[g] | out_im[g] | bf_a_re[g] | bf_a_im[g] | bf_b_re[g] | bf_b_im[g];
        n_cmp++;
        if (ctl !== 10'b10_0000_0000) begin
            n_err++;
            $display("FAIL %s inst%0d idle controls: got %b want %b", nm, g, ctl, 10'b10_0000_0000);
        end
        n_cmp++;
        if (dat !== 32'h0) begin
            n_err++;
            $display("FAIL %s inst%0d idle data: got %h want 0", nm, g, dat);
        end
    endtask

    task automatic send_frame(input int g, input bit gaps, input bit inject);
        int tmo;
        for (int n = 0; n < 8; n++) begin
            if (gaps) begin
                in_valid[g] = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            in_valid[g] = 1'b1;
            in_re[g]    = fr_re[n];
            in_im[g]    = fr_im[n];
            stray[g]    = inject && (n == 4);
            tmo = 0;
            while (!in_ready[g] && tmo < 100) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL send inst%0d sample %0d: in_ready stuck low, want 1", g, n);
                in_valid[g] = 1'b0;
                stray[g]    = 1'b0;
                return;
            end
            @(negedge clk);
            stray[g] = 1'b0;
        end
        in_valid[g] = 1'b0;
    endtask

    task automatic run_compute(input int g, input string nm);
        int          cyc;
        int          ni;
        logic [23:0] rs;
        cyc = 0;
        ni  = 0;
        rs  = '0;
        while (!out_valid[g] && cyc < 200) begin
            if (bf_in_en[g]) begin
                rs = {rs[21:0], bf_rotate[g]};
                ni++;
            end
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (cyc != 3 * (4 + ((g == 0) ? 1 : 3))) begin
            n_err++;
            $display("FAIL %s inst%0d compute cycles: got %0d want %0d", nm, g, cyc, 3 * (4 + ((g == 0) ? 1 : 3)));
        end
        n_cmp++;
        if (ni != 12 || rs !== ROT_SEQ) begin
            n_err++;
            $display("FAIL %s inst%0d issues/rotates: got %0d/%h want 12/%h", nm, g, ni, rs, ROT_SEQ);
        end
    endtask

    task automatic recv_frame(input int g, input int stall_k, input string nm);
        int tmo;
        out_ready[g] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tmo = 0;
            while (!out_valid[g] && tmo < 200) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s inst%0d bin%0d: out_valid stuck low, want 1", nm, g, k);
                return;
            end
            if (k == stall_k) begin
                out_ready[g] = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (!out_valid[g] || out_idx[g] !== 3'(k) || out_re[g] !== ex_re[k] || out_im[g] !== ex_im[k]) begin
                        n_err++;
                        $display("FAIL %s inst%0d stall cycle %0d: got v%b idx%0d %h/%h want v1 idx%0d %h/%h",
                                 nm, g, c, out_valid[g], out_idx[g], out_re[g], out_im[g], k, ex_re[k], ex_im[k]);
                    end
                end
                out_ready[g] = 1'b1;
            end
            n_cmp++;
            if (out_idx[g] !== 3'(k) || out_last[g] !== (k == 7)) begin
                n_err++;
                $display("FAIL %s inst%0d bin%0d idx/last: got %0d/%b want %0d/%b", nm, g, k, out_idx[g], out_last[g], k, k == 7);
            end
            n_cmp++;
            if (out_re[g] !== ex_re[k] || out_im[g] !== ex_im[k]) begin
                n_err++;
                $display("FAIL %s inst%0d bin%0d data: got %h/%h want %h/%h", nm, g, k, out_re[g], out_im[g], ex_re[k], ex_im[k]);
            end
            @(negedge clk);
        end
        out_ready[g] = 1'b0;
        n_cmp++;
        if (out_valid[g] !== 1'b0 || in_ready[g] !== 1'b1 || busy[g] !== 1'b0) begin
            n_err++;
            $display("FAIL %s inst%0d after frame v/rdy/busy: got %b%b%b want 010", nm, g, out_valid[g], in_ready[g], busy[g]);
        end
    endtask

    task automatic load_impulse();
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = '0; fr_im[i] = '0; ex_re[i] = E; ex_im[i] = '0;
        end
        fr_re[0] = ONE;
    endtask

    task automatic load_complex();
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = '0; fr_im[i] = '0;
        end
        fr_im[0] = ONE;
        fr_re[2] = ONE;
        ex_re = '{E, 32'h0, NE, 32'h0, E, 32'h0, NE, 32'h0};
        ex_im = '{E, 32'h0, E, E2, E, 32'h0, E, E2};
    endtask

    task automatic test_reset();
        check_idle(0, "reset");
        check_idle(1, "reset");
    endtask

    task automatic test_impulse();
        load_impulse();
        send_frame(0, 1'b0, 1'b0);
        run_compute(0, "impulse");
        recv_frame(0, -1, "impulse");
    endtask

    task automatic test_dc();
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = ONE; fr_im[i] = '0; ex_re[i] = '0; ex_im[i] = '0;
        end
        ex_re[0] = ONE;
        send_frame(0, 1'b0, 1'b0);
        run_compute(0, "dc");
        recv_frame(0, -1, "dc");
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = (i % 2 == 0) ? ONE : 32'hFFFF0000;
            fr_im[i] = '0; ex_re[i] = '0; ex_im[i] = '0;
        end
        ex_re[4] = ONE;
        send_frame(0, 1'b0, 1'b0);
        run_compute(0, "alternating");
        recv_frame(0, -1, "alternating");
    endtask

    task automatic test_complex();
        load_complex();
        send_frame(0, 1'b0, 1'b1);
        run_compute(0, "complex");
        recv_frame(0, -1, "complex");
    endtask

    task automatic test_backpressure();
        load_complex();
        send_frame(0, 1'b1, 1'b0);
        recv_frame(0, 3, "backpressure");
    endtask

    task automatic test_reset_mid_issue();
        int cnt;
        int t;
        load_impulse();
        send_frame(0, 1'b0, 1'b0);
        cnt = 0;
        t = 0;
        while (cnt < 7 && t < 100) begin
            if (bf_in_en[0]) cnt++;
            if (cnt < 7) begin
                @(negedge clk);
                t++;
            end
        end
        n_cmp++;
        if (cnt != 7) begin
            n_err++;
            $display("FAIL midreset issue count: got %0d want 7", cnt);
        end
        rst_n = 1'b0;
        #1;
        check_idle(0, "midreset async");
        @(negedge clk);
        check_idle(0, "midreset held");
        rst_n    = 1'b1;
        stray[0] = 1'b1;
        @(negedge clk);
        stray[0] = 1'b0;
        check_idle(0, "midreset stray");
        load_impulse();
        send_frame(0, 1'b0, 1'b0);
        run_compute(0, "post-reset impulse");
        recv_frame(0, -1, "post-reset impulse");
    endtask

    task automatic test_back_to_back();
        load_impulse();
        send_frame(1, 1'b0, 1'b1);
        run_compute(1, "lat3 impulse");
        recv_frame(1, -1, "lat3 impulse");
        load_complex();
        send_frame(1, 1'b0, 1'b0);
        run_compute(1, "lat3 complex");
        recv_frame(1, -1, "lat3 complex");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            in_valid[g]  = 1'b0;
            in_re[g]     = '0;
            in_im[g]     = '0;
            out_ready[g] = 1'b0;
            stray[g]     = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_impulse();
        test_dc();
        test_alternating();
        test_complex();
        test_backpressure();
        test_reset_mid_issue();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
